wbr_chain: RTL and testbench
============================

Name: wbr_chain

Overview:
- Parametrised IEEE P1500 wrapper boundary register (WBR) for the s349 core wrapper.
- Generalises the fixed 3-bit shift register to WIDTH cells.
- Each cell has a shift/capture stage and a separate update stage.
- Functional mode passes core I/O straight through. Test mode drives outputs from the update stage.
- Sits between the wrapper serial port (WSI/WSO) and the core functional boundary. Controlled by the wrapper instruction decoder's ShiftWR/CaptureWR/UpdateWR strobes.

Parameters:
- WIDTH, 3: number of boundary cells (>=2).
- UPD_RST, 0: reset value loaded into the update register; WIDTH bits.

Ports:
- clk  in  1  wrapper clock; all state updates on the rising edge.
- WRST  in  1  asynchronous, active-high reset.
- WSI  in  1  wrapper serial input.
- WSO  out  1  wrapper serial output.
- ShiftWR  in  1  shift enable.
- CaptureWR  in  1  capture enable.
- UpdateWR  in  1  update enable.
- test_mode  in  1  0 = functional pass-through, 1 = drive cfo from the update register.
- cfi  in  WIDTH  functional data arriving at the boundary.
- cfo  out  WIDTH  data delivered across the boundary.

Behaviour:
- State:
  - sr[WIDTH-1:0]: shift/capture stage.
  - ur[WIDTH-1:0]: update stage.
- Reset:
  - WRST=1 sets sr=0 and ur=UPD_RST immediately, without waiting for clk.
  - While WRST=1, WSO=0, and cfo follows the mux rule using ur=UPD_RST.
  - Reset asserted mid-shift aborts the shift; no partial data is kept.
  - The first rising edge with WRST=0 applies normal rules.
- sr next-state, evaluated on each rising edge in priority order:
  1. ShiftWR=1: sr <= {WSI, sr[WIDTH-1:1]}. WSI enters at the MSB and data moves toward bit 0.
  2. Else CaptureWR=1: sr <= cfi.
  3. Else: sr holds.
  - ShiftWR has priority over CaptureWR when both are high. No error is flagged.
- ur next-state:
  - UpdateWR=1: ur <= sr, using the sr value before this edge.
  - Else: ur holds.
  - UpdateWR is independent of ShiftWR/CaptureWR. With UpdateWR and ShiftWR both high, ur takes the pre-shift sr while sr shifts in the same edge.
- WSO = sr[0], combinational from the register.
  - It changes only after a clock edge or reset; no WSI-to-WSO combinational path.
- cfo = test_mode ? ur : cfi, purely combinational.
  - Toggling test_mode takes effect in the same cycle and does not alter sr or ur.
- Latency:
  - A bit on WSI appears on WSO after WIDTH shift edges.
  - Captured data is at WSO immediately: sr[0]=cfi[0] after the capture edge.
  - Updated data reaches cfo one edge after UpdateWR, when test_mode=1.
- Gaps in ShiftWR (hold cycles) do not lose data.
- No X propagation from WSI when ShiftWR=0.
- Synthesizable; no latches; single clock domain.

Test Plan:
(All scenarios use WIDTH=3, UPD_RST=0.)
1. Reset:
   - Stimulus: WRST=1 for 2 cycles, cfi=3'b011, test_mode=0.
   - Required: WSO=0, cfo=3'b011. With test_mode=1: cfo=3'b000. Release WRST, no strobes: values unchanged.
2. Serial load:
   - Stimulus: ShiftWR=1, WSI=1,0,1 on three edges.
   - Required: sr=100, 010, 101; WSO=0, 0, 1.
   - Then UpdateWR=1 for 1 cycle with test_mode=1: cfo=3'b101 after that edge.
3. Capture and unload:
   - Stimulus: cfi=3'b110, CaptureWR=1 for 1 edge; then ShiftWR=1, WSI=0 for 3 edges.
   - Required: WSO=0 after capture, then 1, 1, 0. Final sr=000.
4. Simultaneous strobes:
   - Stimulus: sr=3'b101, cfi=3'b010, ShiftWR=CaptureWR=UpdateWR=1, WSI=0 for one edge.
   - Required: sr=3'b010 (shift wins), ur=3'b101 (pre-shift value).
5. Reset mid-operation:
   - Stimulus: after 2 of 3 shifts with WSI=1, assert WRST asynchronously between edges.
   - Required: sr=0, ur=0, and WSO=0 before the next edge.
   - Then 3 fresh shifts of 1,1,1: sr=3'b111.
6. Mode switch:
   - Stimulus: ur=3'b101, cfi=3'b010; toggle test_mode 0->1->0 with no clock edge in between.
   - Required: cfo=010, 101, 010 combinationally; sr and ur unchanged.

Source files
------------

// File: rtl/wbr_chain.sv
// P1500 wrapper boundary register: WIDTH shift/capture cells, each backed by an
// update cell that drives the core boundary while test_mode is high.
module wbr_chain #(
  parameter int unsigned           WIDTH   = 3,
  parameter logic [WIDTH-1:0]      UPD_RST = '0
) (
  input  logic             clk,
  input  logic             WRST,
  input  logic             WSI,
  output logic             WSO,
  input  logic             ShiftWR,
  input  logic             CaptureWR,
  input  logic             UpdateWR,
  input  logic             test_mode,
  input  logic [WIDTH-1:0] cfi,
  output logic [WIDTH-1:0] cfo
);

  logic [WIDTH-1:0] sr_r;
  logic [WIDTH-1:0] ur_r;
  logic [WIDTH-1:0] sr_next_s;

  // Shift/capture next state: shift wins over capture, WSI enters at the MSB.
  always_comb begin
    sr_next_s = sr_r;
    if (ShiftWR) begin
      sr_next_s = {WSI, sr_r[WIDTH-1:1]};
    end else if (CaptureWR) begin
      sr_next_s = cfi;
    end else begin
      sr_next_s = sr_r;
    end
  end

  // Shift/capture stage register.
  always_ff @(posedge clk or posedge WRST) begin
    if (WRST) begin
      sr_r <= {WIDTH{1'b0}};
    end else begin
      sr_r <= sr_next_s;
    end
  end

  // Update stage samples the pre-edge shift stage, independent of shift/capture.
  always_ff @(posedge clk or posedge WRST) begin
    if (WRST) begin
      ur_r <= UPD_RST;
    end else if (UpdateWR) begin
      ur_r <= sr_r;
    end else begin
      ur_r <= ur_r;
    end
  end

  // Serial output comes straight from cell 0; boundary mux selects update stage in test mode.
  always_comb begin
    WSO = sr_r[0];
    if (test_mode) begin
      cfo = ur_r;
    end else begin
      cfo = cfi;
    end
  end

endmodule

// File: tb/tb_wbr_chain.sv
// Directed bench for wbr_chain (WIDTH=3): arithmetic reference model checked
// every negative edge, plus hand-computed literal checks of each scenario.
module tb_wbr_chain;

  localparam int W = 3;

  logic         clk;
  logic         WRST;
  logic         WSI;
  logic         WSO;
  logic         ShiftWR;
  logic         CaptureWR;
  logic         UpdateWR;
  logic         test_mode;
  logic [W-1:0] cfi;
  logic [W-1:0] cfo;

  int checks;
  int errors;

  wbr_chain #(.WIDTH(W), .UPD_RST(3'b000)) dut (
    .clk(clk), .WRST(WRST), .WSI(WSI), .WSO(WSO),
    .ShiftWR(ShiftWR), .CaptureWR(CaptureWR), .UpdateWR(UpdateWR),
    .test_mode(test_mode), .cfi(cfi), .cfo(cfo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: chain contents held as integers, shifting is a divide by two.
  int m_sr;
  int m_ur;
  bit m_valid;

  always @(posedge clk or posedge WRST) begin
    if (WRST) begin
      m_sr    <= 0;
      m_ur    <= 0;
      m_valid <= 1'b1;
    end else begin
      if (UpdateWR) m_ur <= m_sr;
      if (ShiftWR) m_sr <= (m_sr / 2) + (int'(WSI) * (1 << (W - 1)));
      else if (CaptureWR) m_sr <= int'(cfi);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_wso", int'(WSO), m_sr % 2);
      check("model_cfo", int'(cfo), test_mode ? m_ur : int'(cfi));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0;
    WRST = 1'b0; WSI = 1'b0; ShiftWR = 1'b0; CaptureWR = 1'b0; UpdateWR = 1'b0;
    test_mode = 1'b0; cfi = 3'b011;

    // 1. Reset
    #1 WRST = 1'b1;
    tick(); tick();
    check("rst_wso", int'(WSO), 0);
    check("rst_cfo_func", int'(cfo), 3);
    test_mode = 1'b1; #1;
    check("rst_cfo_test", int'(cfo), 0);
    WRST = 1'b0;
    tick();
    check("rel_cfo", int'(cfo), 0);
    check("rel_wso", int'(WSO), 0);
    test_mode = 1'b0;

    // 2. Serial load 1,0,1 then update
    ShiftWR = 1'b1; WSI = 1'b1; tick();
    check("load1_sr", int'(dut.sr_r), 4); check("load1_wso", int'(WSO), 0);
    WSI = 1'b0; tick();
    check("load2_sr", int'(dut.sr_r), 2); check("load2_wso", int'(WSO), 0);
    WSI = 1'b1; tick();
    check("load3_sr", int'(dut.sr_r), 5); check("load3_wso", int'(WSO), 1);
    ShiftWR = 1'b0; UpdateWR = 1'b1; test_mode = 1'b1; tick();
    UpdateWR = 1'b0;
    check("upd_cfo", int'(cfo), 5);

    // 3. Capture then unload
    test_mode = 1'b0; cfi = 3'b110; CaptureWR = 1'b1; tick();
    CaptureWR = 1'b0;
    check("cap_sr", int'(dut.sr_r), 6); check("cap_wso", int'(WSO), 0);
    ShiftWR = 1'b1; WSI = 1'b0;
    tick(); check("unl1_wso", int'(WSO), 1);
    tick(); check("unl2_wso", int'(WSO), 1);
    tick(); check("unl3_wso", int'(WSO), 0);
    check("unl_sr", int'(dut.sr_r), 0);

    // 4. Simultaneous strobes from sr=101
    WSI = 1'b1; tick(); WSI = 1'b0; tick(); WSI = 1'b1; tick();
    check("pre4_sr", int'(dut.sr_r), 5);
    cfi = 3'b010; CaptureWR = 1'b1; UpdateWR = 1'b1; WSI = 1'b0; tick();
    ShiftWR = 1'b0; CaptureWR = 1'b0; UpdateWR = 1'b0;
    check("simul_sr", int'(dut.sr_r), 2);
    check("simul_ur", int'(dut.ur_r), 5);
    test_mode = 1'b1; #1;
    check("simul_cfo", int'(cfo), 5);
    test_mode = 1'b0;

    // 5. Reset between edges mid-shift
    ShiftWR = 1'b1; WSI = 1'b1; tick(); tick();
    check("mid_sr", int'(dut.sr_r), 6);
    #2 WRST = 1'b1; #1;
    check("arst_sr", int'(dut.sr_r), 0);
    check("arst_ur", int'(dut.ur_r), 0);
    check("arst_wso", int'(WSO), 0);
    tick();
    check("arst_hold_sr", int'(dut.sr_r), 0);
    WRST = 1'b0;
    tick(); tick(); tick();
    check("fresh_sr", int'(dut.sr_r), 7);
    check("fresh_wso", int'(WSO), 1);

    // 6. Mode switch with ur=101, no clock edge in between
    WSI = 1'b1; tick(); WSI = 1'b0; tick(); WSI = 1'b1; tick();
    ShiftWR = 1'b0; UpdateWR = 1'b1; tick();
    UpdateWR = 1'b0; cfi = 3'b010; WSI = 1'b0;
    test_mode = 1'b0; #1; check("mode0_cfo", int'(cfo), 2);
    test_mode = 1'b1; #1; check("mode1_cfo", int'(cfo), 5);
    test_mode = 1'b0; #1; check("mode0b_cfo", int'(cfo), 2);
    check("mode_sr", int'(dut.sr_r), 5);
    check("mode_ur", int'(dut.ur_r), 5);

    // Idle with shift off: chain must hold across gaps
    tick(); tick();
    check("idle_sr", int'(dut.sr_r), 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
